// File: rtl/menu_pkg.sv
// rtl/menu_pkg.sv - shared types and constants for the menu screen
// FSM states, glyph codes, title string and background colour helper.
package menu_pkg;

  typedef enum logic [1:0] {
    BROWSE = 2'd0,
    COMMIT = 2'd1,
    LOCKED = 2'd2
  } menu_state_t;

  localparam logic [5:0] GLYPH_ARROW  = 6'd0;
  localparam logic [5:0] GLYPH_SPACE  = 6'd37;
  localparam logic [5:0] GLYPH_DIGIT0 = 6'd1;

  localparam int TITLE_LEN = 11;
  // "BATTLE CITY"
  localparam logic [5:0] TITLE_CODES [TITLE_LEN] = '{
    6'd12, 6'd11, 6'd30, 6'd30, 6'd22, 6'd15, 6'd37, 6'd13, 6'd19, 6'd30, 6'd35
  };
  // "MAP " prefix of each item; the digit follows
  localparam logic [5:0] ITEM_CODES [4] = '{6'd23, 6'd11, 6'd26, 6'd37};

  // Top three bits of a channel set, rest clear
  function automatic logic [15:0] bg_channel(input int chan_bits);
    return 16'hE000 >> (16 - chan_bits);
  endfunction

endpackage

// File: rtl/ascii_rom.sv
// rtl/ascii_rom.sv - combinational glyph ROM, addr {code[5:0], row[3:0]}
// Glyphs are 8x8 art with each row doubled to fill 16 rows; bit 7 is leftmost.
module ascii_rom (
  input  logic [9:0] i_addr,
  output logic [7:0] o_data
);

  logic [63:0] w_glyph;
  logic [2:0]  w_sel;
  logic        w_unused;

  assign w_unused = &{1'b0, i_addr[0]};
  assign w_sel    = 3'd7 - i_addr[3:1];

  always_comb begin
    case (i_addr[9:4])
      6'd0:    w_glyph = 64'h10181C1E1C181000;
      6'd1:    w_glyph = 64'h3C666E7666663C00;
      6'd2:    w_glyph = 64'h1838181818187E00;
      6'd3:    w_glyph = 64'h3C66060C30607E00;
      6'd4:    w_glyph = 64'h3C66061C06663C00;
      6'd5:    w_glyph = 64'h0C1C3C6C7E0C0C00;
      6'd6:    w_glyph = 64'h7E607C0606663C00;
      6'd7:    w_glyph = 64'h3C607C6666663C00;
      6'd11:   w_glyph = 64'h183C66667E666600;
      6'd12:   w_glyph = 64'h7C66667C66667C00;
      6'd13:   w_glyph = 64'h3C66606060663C00;
      6'd15:   w_glyph = 64'h7E60607C60607E00;
      6'd19:   w_glyph = 64'h3C18181818183C00;
      6'd22:   w_glyph = 64'h6060606060607E00;
      6'd23:   w_glyph = 64'h63777F6B63636300;
      6'd26:   w_glyph = 64'h7C66667C60606000;
      6'd30:   w_glyph = 64'h7E18181818181800;
      6'd35:   w_glyph = 64'h6666663C18181800;
      default: w_glyph = 64'h0;
    endcase
    o_data = w_glyph[{w_sel, 3'b000} +: 8];
  end

endmodule

// File: rtl/menu_select_button_repeat.sv
// rtl/menu_select_button_repeat.sv - button edge detect with held-key auto-repeat
// Emits a one-cycle move on the rising edge, after REPEAT_DELAY held frames, then every REPEAT_RATE frames.
module button_repeat #(
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 6
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_level,
  input  logic i_tick,
  input  logic i_clear,
  output logic o_move
);

  localparam int HW = $clog2(REPEAT_DELAY + 1);
  localparam int RW = $clog2(REPEAT_RATE + 1);
  localparam logic [HW-1:0] DLY     = HW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RT_LAST = RW'(REPEAT_RATE - 1);

  logic          r_prev;
  logic [HW-1:0] r_hold, w_hold_nxt;
  logic [RW-1:0] r_rate, w_rate_nxt;
  logic          w_fire;

  always_comb begin
    w_hold_nxt = r_hold;
    w_rate_nxt = r_rate;
    w_fire     = 1'b0;
    if (i_clear || !i_level) begin
      w_hold_nxt = '0;
      w_rate_nxt = '0;
    end else if (i_tick) begin
      // hold saturates at DLY; from then on the rate counter paces repeats
      if (r_hold != DLY) begin
        w_hold_nxt = r_hold + 1'b1;
        w_fire     = ((r_hold + 1'b1) == DLY);
      end else if (r_rate == RT_LAST) begin
        w_rate_nxt = '0;
        w_fire     = 1'b1;
      end else begin
        w_rate_nxt = r_rate + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_prev <= 1'b0;
      r_hold <= '0;
      r_rate <= '0;
    end else begin
      r_prev <= i_level;
      r_hold <= w_hold_nxt;
      r_rate <= w_rate_nxt;
    end
  end

  assign o_move = (i_level & ~r_prev) | w_fire;

endmodule

// File: rtl/menu_select.sv
// rtl/menu_select.sv - map selection menu: cursor, selection handshake and text rendering
// Optional MENU_BLINK_EN makes the cursor arrow blink with a 32-frame period.
module menu_select
  import menu_pkg::*;
#(
  parameter int COLOR_BITS   = 24,
  parameter int NUM_ITEMS    = 4,
  parameter int ITEM_ROW0    = 9,
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 6
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          up_i,
  input  logic                          down_i,
  input  logic                          confirm_i,
  input  logic                          reopen_i,
  input  logic                          frame_tick_i,
  input  logic [9:0]                    hpos_i,
  input  logic [9:0]                    vpos_i,
  output logic [COLOR_BITS/3-1:0]       menu_red_o,
  output logic [COLOR_BITS/3-1:0]       menu_green_o,
  output logic [COLOR_BITS/3-1:0]       menu_blue_o,
  output logic [$clog2(NUM_ITEMS)-1:0]  map_type_o,
  output logic                          sel_valid_o,
  input  logic                          sel_ready_i,
  output logic                          menu_active_o
);

  localparam int CW    = COLOR_BITS / 3;
  localparam int CUR_W = $clog2(NUM_ITEMS);
  localparam logic [CUR_W-1:0] LAST    = CUR_W'(NUM_ITEMS - 1);
  localparam logic [4:0]       ROW0    = 5'(ITEM_ROW0);
  localparam logic [4:0]       NI5     = 5'(NUM_ITEMS);
  localparam logic [15:0]      BG_FULL = bg_channel(CW);
  localparam logic [CW-1:0]    BG      = BG_FULL[CW-1:0];

  menu_state_t      r_state, w_state_nxt;
  logic [CUR_W-1:0] r_cursor;
  logic             r_confirm_prev;
  logic             w_confirm_edge, w_browse, w_clear;
  logic             w_up_raw, w_down_raw, w_up_move, w_down_move;
  logic             w_arrow_on;

  assign w_browse       = (r_state == BROWSE);
  assign w_clear        = (r_state == LOCKED) & reopen_i;
  assign w_confirm_edge = confirm_i & ~r_confirm_prev;

  button_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_up (
    .i_clk(clk_i), .i_reset(reset_i), .i_level(up_i), .i_tick(frame_tick_i),
    .i_clear(w_clear), .o_move(w_up_raw)
  );

  button_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_down (
    .i_clk(clk_i), .i_reset(reset_i), .i_level(down_i), .i_tick(frame_tick_i),
    .i_clear(w_clear), .o_move(w_down_raw)
  );

  // Simultaneous up and down cancel each other
  assign w_up_move   = w_browse & w_up_raw & ~w_down_raw;
  assign w_down_move = w_browse & w_down_raw & ~w_up_raw;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BROWSE:  if (w_confirm_edge) w_state_nxt = COMMIT;
      COMMIT:  if (sel_ready_i)    w_state_nxt = LOCKED;
      LOCKED:  if (reopen_i)       w_state_nxt = BROWSE;
      default: w_state_nxt = BROWSE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state        <= BROWSE;
      r_cursor       <= '0;
      r_confirm_prev <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_confirm_prev <= confirm_i;
      if (w_up_move)
        r_cursor <= (r_cursor == '0) ? LAST : r_cursor - 1'b1;
      else if (w_down_move)
        r_cursor <= (r_cursor == LAST) ? '0 : r_cursor + 1'b1;
    end
  end

  assign map_type_o    = r_cursor;
  assign sel_valid_o   = (r_state == COMMIT);
  assign menu_active_o = (r_state != LOCKED);

`ifdef MENU_BLINK_EN
  logic [4:0] r_blink;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                     r_blink <= '0;
    else if (w_up_move | w_down_move) r_blink <= '0;
    else if (frame_tick_i)           r_blink <= r_blink + 1'b1;
  end

  assign w_arrow_on = ~r_blink[4];
`else
  assign w_arrow_on = 1'b1;
`endif

  logic [3:0] w_title_idx;
  logic [4:0] w_item_row;
  logic [2:0] w_item_col;
  logic       w_title_hit, w_row_hit, w_item_hit, w_on_cursor, w_arrow_hit;
  logic [5:0] w_code;
  logic [3:0] w_row;
  logic [2:0] w_bit_sel;
  logic [7:0] w_glyph;
  logic       w_ink, w_red_ink;
  logic       w_unused;

  assign w_unused    = &{1'b0, hpos_i[0], vpos_i[0]};
  assign w_title_idx = hpos_i[8:5] - 4'd5;
  assign w_title_hit = (vpos_i[9:7] == 3'd1) && (hpos_i[9:5] >= 5'd5) && (hpos_i[9:5] <= 5'd15);
  assign w_item_row  = vpos_i[9:5] - ROW0;
  assign w_row_hit   = (vpos_i[9:5] >= ROW0) && (w_item_row < NI5);
  assign w_item_col  = hpos_i[6:4] - 3'd1;
  assign w_item_hit  = w_row_hit && (hpos_i[9:4] >= 6'd17) && (hpos_i[9:4] <= 6'd21);
  assign w_on_cursor = w_row_hit && (w_item_row == 5'(r_cursor));
  assign w_arrow_hit = w_on_cursor && (hpos_i[9:4] == 6'd15) && w_arrow_on;

  always_comb begin
    w_code    = GLYPH_SPACE;
    w_row     = vpos_i[4:1];
    w_bit_sel = ~hpos_i[3:1];
    if (w_title_hit) begin
      w_code    = TITLE_CODES[w_title_idx];
      w_row     = vpos_i[6:3];
      w_bit_sel = ~hpos_i[4:2];
    end else if (w_item_hit) begin
      if (w_item_col == 3'd4) w_code = GLYPH_DIGIT0 + 6'(w_item_row) + 6'd1;
      else                    w_code = ITEM_CODES[w_item_col[1:0]];
    end else if (w_arrow_hit) begin
      w_code = GLYPH_ARROW;
    end
  end

  ascii_rom u_rom (
    .i_addr({w_code, w_row}),
    .o_data(w_glyph)
  );

  assign w_ink     = w_glyph[w_bit_sel] && (w_title_hit || w_item_hit || w_arrow_hit) &&
                     (r_state != LOCKED);
  assign w_red_ink = (w_item_hit && w_on_cursor) || w_arrow_hit;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      menu_red_o   <= BG;
      menu_green_o <= BG;
      menu_blue_o  <= BG;
    end else if (w_ink) begin
      menu_red_o   <= w_red_ink ? {CW{1'b1}} : '0;
      menu_green_o <= '0;
      menu_blue_o  <= '0;
    end else begin
      menu_red_o   <= BG;
      menu_green_o <= BG;
      menu_blue_o  <= BG;
    end
  end

endmodule

// File: tb/tb_menu_select.sv
// tb/tb_menu_select.sv - randomized self-checking bench for menu_select
// Reference model tracks menu state, cursor and expected pixels with plain arithmetic.
module tb_menu_select;

  localparam int N     = 4;
  localparam int DLY   = 20;
  localparam int RATE  = 6;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       up_i = 1'b0, down_i = 1'b0, confirm_i = 1'b0, reopen_i = 1'b0;
  logic       frame_tick_i = 1'b0, sel_ready_i = 1'b0;
  logic [9:0] hpos_i = '0, vpos_i = '0;
  logic [7:0] menu_red_o, menu_green_o, menu_blue_o;
  logic [1:0] map_type_o;
  logic       sel_valid_o, menu_active_o;

  logic [9:0] ref_addr = '0;
  logic [7:0] ref_data;

  menu_select #(
    .COLOR_BITS(24), .NUM_ITEMS(N), .ITEM_ROW0(9), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .up_i(up_i), .down_i(down_i), .confirm_i(confirm_i),
    .reopen_i(reopen_i), .frame_tick_i(frame_tick_i), .hpos_i(hpos_i), .vpos_i(vpos_i),
    .menu_red_o(menu_red_o), .menu_green_o(menu_green_o), .menu_blue_o(menu_blue_o),
    .map_type_o(map_type_o), .sel_valid_o(sel_valid_o), .sel_ready_i(sel_ready_i),
    .menu_active_o(menu_active_o)
  );

  ascii_rom u_ref_rom (.i_addr(ref_addr), .o_data(ref_data));

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  int title_codes [11] = '{12, 11, 30, 30, 22, 15, 37, 13, 19, 30, 35};
  int item_codes  [4]  = '{23, 11, 26, 37};

  // model: state 0=browse 1=commit 2=locked
  int m_state, m_cur, m_up_held, m_dn_held;
  bit m_up_prev, m_dn_prev, m_cf_prev;

  task automatic model_reset();
    m_state = 0; m_cur = 0; m_up_held = 0; m_dn_held = 0;
    m_up_prev = 0; m_dn_prev = 0; m_cf_prev = 0;
  endtask

  function automatic bit repeat_due(int held);
    return (held == DLY) || (held > DLY && ((held - DLY) % RATE) == 0);
  endfunction

  task automatic model_step(input bit up, dn, cf, tk, rdy, rop);
    bit clr, up_mv, dn_mv;
    clr   = (m_state == 2) && rop;
    up_mv = up && !m_up_prev;
    dn_mv = dn && !m_dn_prev;
    if (clr || !up) m_up_held = 0;
    else if (tk) begin m_up_held++; if (repeat_due(m_up_held)) up_mv = 1; end
    if (clr || !dn) m_dn_held = 0;
    else if (tk) begin m_dn_held++; if (repeat_due(m_dn_held)) dn_mv = 1; end
    case (m_state)
      0: begin
        if (up_mv && !dn_mv) m_cur = (m_cur + N - 1) % N;
        if (dn_mv && !up_mv) m_cur = (m_cur + 1) % N;
        if (cf && !m_cf_prev) m_state = 1;
      end
      1: if (rdy) m_state = 2;
      default: if (rop) m_state = 0;
    endcase
    m_up_prev = up; m_dn_prev = dn; m_cf_prev = cf;
  endtask

  task automatic exp_pixel(input int h, input int v, output logic [23:0] px);
    int code, row, bitn, it;
    bit sel;
    code = -1; row = 0; bitn = 0; sel = 0;
    if (m_state != 2) begin
      if (v / 128 == 1 && h / 32 >= 5 && h / 32 <= 15) begin
        code = title_codes[h / 32 - 5]; row = (v % 128) / 8; bitn = 7 - (h % 32) / 4;
      end else if (v / 32 >= 9 && v / 32 < 9 + N) begin
        it   = v / 32 - 9;
        row  = (v % 32) / 2;
        bitn = 7 - (h % 16) / 2;
        if (h / 16 >= 17 && h / 16 <= 21) begin
          code = (h / 16 - 17 < 4) ? item_codes[h / 16 - 17] : it + 2;
          sel  = (it == m_cur);
        end else if (h / 16 == 15 && it == m_cur) begin
          code = 0; sel = 1;
        end
      end
    end
    px = 24'hE0E0E0;
    if (code >= 0) begin
      ref_addr = {code[5:0], row[3:0]};
      #1;
      if (ref_data[bitn]) px = sel ? 24'hFF0000 : 24'h000000;
    end
  endtask

  logic [23:0] last_pix;

  task automatic step(input bit up, dn, cf, tk, rdy, rop, input int h, input int v);
    logic [23:0] px;
    @(negedge clk_i);
    up_i = up; down_i = dn; confirm_i = cf; frame_tick_i = tk;
    sel_ready_i = rdy; reopen_i = rop; hpos_i = h[9:0]; vpos_i = v[9:0];
    exp_pixel(h, v, px);
    model_step(up, dn, cf, tk, rdy, rop);
    @(posedge clk_i);
    #1;
    last_pix = {menu_red_o, menu_green_o, menu_blue_o};
    check_eq("map", map_type_o, m_cur[1:0]);
    check_eq("valid", sel_valid_o, m_state == 1);
    check_eq("active", menu_active_o, m_state != 2);
    check_eq("pixel", last_pix, px);
  endtask

  initial begin
    int moves;
    logic [1:0] last_map, saved;
    bit lu, ld, lc;
    int h, v;

    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("rst_map", map_type_o, 0);
    check_eq("rst_valid", sel_valid_o, 0);
    check_eq("rst_active", menu_active_o, 1);
    check_eq("rst_pix", {menu_red_o, menu_green_o, menu_blue_o}, 24'hE0E0E0);
    @(negedge clk_i);
    reset_i = 1'b0;

    for (int k = 1; k <= 4; k++) begin
      step(0, 1, 0, 0, 0, 0, 0, 0);
      check_eq("down_seq", map_type_o, k % 4);
      step(0, 0, 0, 0, 0, 0, 0, 0);
    end
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check_eq("up_wrap", map_type_o, 3);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    check_eq("both_nomove", map_type_o, 3);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    moves = 0;
    last_map = map_type_o;
    for (int i = 0; i < 80; i++) begin
      step(0, 1, 0, (i % 2) == 1, 0, 0, 0, 0);
      if (map_type_o != last_map) moves++;
      last_map = map_type_o;
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("repeat_moves", moves, 5);
    check_eq("repeat_pos", map_type_o, 0);

    step(0, 0, 0, 0, 0, 0, 160, 128);
    check_eq("pix_B0_off", last_pix, 24'hE0E0E0);
    step(0, 0, 0, 0, 0, 0, 164, 128);
    check_eq("pix_B0_on", last_pix, 24'h000000);
    step(0, 0, 0, 0, 0, 0, 246, 288);
    check_eq("pix_arrow", last_pix, 24'hFF0000);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("pix_origin", last_pix, 24'hE0E0E0);

    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    saved = map_type_o;
    check_eq("commit_valid", sel_valid_o, 1);
    for (int i = 0; i < 10; i++) begin
      step((i % 3) == 0, (i % 3) == 1, 0, 1, 0, 0, 0, 0);
      check_eq("hold_valid", sel_valid_o, 1);
      check_eq("hold_map", map_type_o, saved);
    end
    step(0, 0, 0, 0, 1, 0, 0, 0);
    check_eq("xfer_valid", sel_valid_o, 0);
    check_eq("locked_active", menu_active_o, 0);
    step(0, 0, 0, 0, 0, 0, 164, 128);
    check_eq("locked_pix", last_pix, 24'hE0E0E0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    check_eq("reopen_active", menu_active_o, 1);
    check_eq("reopen_map", map_type_o, saved);

    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    #1 reset_i = 1'b1;
    #1;
    check_eq("async_valid", sel_valid_o, 0);
    check_eq("async_map", map_type_o, 0);
    check_eq("async_active", menu_active_o, 1);
    @(negedge clk_i);
    reset_i = 1'b0;
    model_reset();

    lu = 0; ld = 0; lc = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) lu = ~lu;
      if ($urandom_range(39) == 0) ld = ~ld;
      if ($urandom_range(19) == 0) lc = ~lc;
      if ($urandom_range(1) == 0) begin
        h = $urandom_range(399); v = $urandom_range(450, 100);
      end else begin
        h = $urandom_range(1023); v = $urandom_range(1023);
      end
      step(lu, ld, lc, $urandom_range(1) == 0, $urandom_range(2) == 0,
           $urandom_range(14) == 0, h, v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
